// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - writeback write queue between EX/MEM results and the register file write port
//
// Buffers up to two register results per cycle (MEM first, then EX) in a
// circular FIFO and drains one entry per cycle into the register file.
// A lookup port reports pending writes to the operand-read side.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   mem_valid/mem_ready/mem_rd/mem_data   MEM-stage result handshake
//   ex_valid/ex_ready/ex_rd/ex_data       EX-stage result handshake
//   rf_hold                         suppresses draining while high
//   rf_we/rf_rw/rf_pw               register file write port (head entry)
//   ra/rb                           operand lookup addresses
//   hit_a/hit_b                     pending write matches ra/rb
//   fwd_a/fwd_b                     youngest matching pending data
//   count                           current occupancy
//
// Build option WB_FORWARD_EN: when defined, fwd_a/fwd_b carry the youngest
// matching entry data; otherwise they are tied to 0 and hit_x is a stall flag.

module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [4:0]                 mem_rd,
    input  logic [31:0]                mem_data,
    input  logic                       ex_valid,
    output logic                       ex_ready,
    input  logic [4:0]                 ex_rd,
    input  logic [31:0]                ex_data,
    input  logic                       rf_hold,
    output logic                       rf_we,
    output logic [4:0]                 rf_rw,
    output logic [31:0]                rf_pw,
    input  logic [4:0]                 ra,
    input  logic [4:0]                 rb,
    output logic                       hit_a,
    output logic                       hit_b,
    output logic [31:0]                fwd_a,
    output logic [31:0]                fwd_b,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic          ready;
    logic          mem_acc;
    logic          ex_acc;
    logic          pop;
    logic [PW-1:0] ex_slot;

    // Ready depends only on registered occupancy, leaving room for two
    // entries so a simultaneous MEM+EX accept always fits.
    assign ready     = (count_q <= CW'(DEPTH - 2));
    assign mem_ready = ready;
    assign ex_ready  = ready;

    // x0 writes complete the handshake but never occupy a slot.
    assign mem_acc = mem_valid && ready && (mem_rd != 5'd0);
    assign ex_acc  = ex_valid  && ready && (ex_rd  != 5'd0);
    assign ex_slot = wr_ptr + PW'(mem_acc);

    assign pop   = (count_q != '0) && !rf_hold;
    assign rf_we = pop;
    assign rf_rw = (count_q != '0) ? rd_q[rd_ptr]   : 5'd0;
    assign rf_pw = (count_q != '0) ? data_q[rd_ptr] : 32'd0;
    assign count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(mem_acc) + PW'(ex_acc);
            rd_ptr  <= rd_ptr + PW'(pop);
            count_q <= count_q + CW'(mem_acc) + CW'(ex_acc) - CW'(pop);
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (mem_acc) begin
            rd_q[wr_ptr]   <= mem_rd;
            data_q[wr_ptr] <= mem_data;
        end
        if (ex_acc) begin
            rd_q[ex_slot]   <= ex_rd;
            data_q[ex_slot] <= ex_data;
        end
    end

    // Walk entries oldest to youngest so the last match found is the youngest.
    logic [PW-1:0] idx;
`ifdef WB_FORWARD_EN
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        fwd_a = 32'd0;
        fwd_b = 32'd0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count_q) begin
                if ((ra != 5'd0) && (rd_q[idx] == ra)) begin
                    hit_a = 1'b1;
                    fwd_a = data_q[idx];
                end
                if ((rb != 5'd0) && (rd_q[idx] == rb)) begin
                    hit_b = 1'b1;
                    fwd_b = data_q[idx];
                end
            end
        end
    end
`else
    assign fwd_a = 32'd0;
    assign fwd_b = 32'd0;

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count_q) begin
                if ((ra != 5'd0) && (rd_q[idx] == ra)) hit_a = 1'b1;
                if ((rb != 5'd0) && (rd_q[idx] == rb)) hit_b = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - randomized and directed check of wb_write_queue against a queue model

module tb_wb_write_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, ex_valid, rf_hold;
    logic        mem_ready, ex_ready;
    logic [4:0]  mem_rd, ex_rd, ra, rb, rf_rw;
    logic [31:0] mem_data, ex_data, rf_pw, fwd_a, fwd_b;
    logic        rf_we, hit_a, hit_b;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
        .rf_hold(rf_hold), .rf_we(rf_we), .rf_rw(rf_rw), .rf_pw(rf_pw),
        .ra(ra), .rb(rb), .hit_a(hit_a), .hit_b(hit_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Youngest pending write to register r, per the model.
    task automatic lookup(input logic [4:0] r, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = 32'd0;
        if (r != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].rd == r) begin
                    h = 1'b1;
                    d = q[i].d;
                end
            end
        end
`ifndef WB_FORWARD_EN
        d = 32'd0;
`endif
    endtask

    // Compare every output against the model, then advance the model by one edge.
    task automatic check_and_advance();
        int          n;
        logic        rdy, we, ha, hb;
        logic [31:0] da, db;
        n   = q.size();
        rdy = (n <= DEPTH - 2);
        we  = (n != 0) && !rf_hold;
        lookup(ra, ha, da);
        lookup(rb, hb, db);
        chk("count", 32'(count), 32'(n));
        chk("mem_ready", 32'(mem_ready), 32'(rdy));
        chk("ex_ready", 32'(ex_ready), 32'(rdy));
        chk("rf_we", 32'(rf_we), 32'(we));
        chk("rf_rw", 32'(rf_rw), (n != 0) ? 32'(q[0].rd) : 32'd0);
        chk("rf_pw", rf_pw, (n != 0) ? q[0].d : 32'd0);
        chk("hit_a", 32'(hit_a), 32'(ha));
        chk("hit_b", 32'(hit_b), 32'(hb));
        chk("fwd_a", fwd_a, da);
        chk("fwd_b", fwd_b, db);
        if (we) void'(q.pop_front());
        if (mem_valid && rdy && mem_rd != 5'd0) q.push_back('{mem_rd, mem_data});
        if (ex_valid && rdy && ex_rd != 5'd0) q.push_back('{ex_rd, ex_data});
    endtask

    // Drive one cycle of inputs, check at the falling edge, return just after the rising edge.
    task automatic step(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                        input logic hold, input logic [4:0] a, input logic [4:0] b);
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        ex_valid  = ev; ex_rd  = erd; ex_data  = ed;
        rf_hold   = hold; ra = a; rb = b;
        @(negedge clk);
        check_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic hold);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, hold, 5'd0, 5'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        ex_valid  = 1'b0; ex_rd  = '0; ex_data  = '0;
        rf_hold = 1'b0; ra = '0; rb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_ready", 32'({mem_ready, ex_ready}), 32'd3);
        chk("rst_pw", rf_pw, 32'd0);
        rst_n = 1'b1;

        // Single MEM write drains on the next cycle.
        step(1'b1, 5'd5, 32'h14, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        chk("t1_we", 32'(rf_we), 32'd1);
        chk("t1_rw", 32'(rf_rw), 32'd5);
        chk("t1_pw", rf_pw, 32'h14);
        idle(1'b0);
        chk("t1_count", 32'(count), 32'd0);

        // Same-cycle double write to rd 3: MEM older, EX youngest.
        step(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd3, 32'h5555, 1'b1, 5'd3, 5'd0);
        chk("t2_count", 32'(count), 32'd2);
        chk("t2_hit_a", 32'(hit_a), 32'd1);
`ifdef WB_FORWARD_EN
        chk("t2_fwd_a", fwd_a, 32'h5555);
`else
        chk("t2_fwd_a", fwd_a, 32'd0);
`endif
        chk("t2_head", rf_pw, 32'hAAAA0000);
        idle(1'b0);
        chk("t2_second", rf_pw, 32'h5555);
        idle(1'b0);

        // Fill under hold until readies drop, then release.
        for (int i = 1; i <= 5; i++)
            step(1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 5'd7);
        chk("t3_count", 32'(count), 32'd3);
        chk("t3_ready", 32'({mem_ready, ex_ready}), 32'd0);
        for (int i = 0; i < 4; i++) idle(1'b0);
        chk("t3_drained", 32'(count), 32'd0);
        chk("t3_ready_back", 32'({mem_ready, ex_ready}), 32'd3);

        // x0 write is consumed without queuing.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_we", 32'(rf_we), 32'd0);
        chk("t4_hit_a", 32'(hit_a), 32'd0);

        // Pending rd 7 seen on rb.
        step(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd7);
        chk("t6_hit_b", 32'(hit_b), 32'd1);
`ifdef WB_FORWARD_EN
        chk("t6_fwd_b", fwd_b, 32'h77);
`else
        chk("t6_fwd_b", fwd_b, 32'd0);
`endif

        // Reset with pending entries discards them immediately.
        step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 5'd1, 5'd2);
        rst_n = 1'b0;
        #1;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_we", 32'(rf_we), 32'd0);
        chk("t5_hit", 32'({hit_a, hit_b}), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b0);
        idle(1'b0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 3) == 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b0);
        chk("final_empty", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
